intc: RTL and testbench
=======================

# intc

Programmable interrupt controller for the MUSB SoC peripheral bus, sitting directly downstream of the GPIO block and the other peripherals. It collects up to 32 interrupt request lines, such as the four sticky per-port GPIO interrupt flags, timers and the UART. Each line is conditioned as level- or rising-edge-sensitive, latched into a pending register and masked. A single registered CPU interrupt line plus the index of the highest-priority active source is presented to the core. Software controls the block through the same single-cycle-ack register bus used by every MUSB peripheral.

## Interface
- N_SRC, 8, number of interrupt sources (1..32); register bits at N_SRC and above read 0 and ignore writes
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- irq_i  input  N_SRC  raw interrupt requests; bit 0 is the highest priority
- intc_address  input  32  byte address; word index = intc_address[4:2]
- intc_data_i  input  32  write data
- intc_wr  input  4  byte-lane write strobes; 4'b0000 means read
- intc_enable  input  1  bus request valid
- intc_data_o  output  32  registered read data
- intc_ready  output  1  one-cycle acknowledge
- irq_o  output  1  interrupt to CPU, registered
- irq_id  output  5  index of the highest-priority active source, registered

## Operation
- Word map (index = address[4:2]):
  - 0 PEND: read-only; writes are acked and ignored.
  - 1 MASK: read/write; 1 enables the source.
  - 2 MODE: read/write; 0 = level, 1 = rising edge.
  - 3 CLR: write-one-to-clear edge pending; reads 0.
  - 4 ID: read returns {irq_o, 26'b0, irq_id}.
  - Indices 5..7 are unimplemented and never acked.
- Handshake:
  - intc_ready <= intc_enable & (index < 5).
  - An access executes only when intc_enable & ~intc_ready, so a held request acts once per ack cycle.
  - An unimplemented index leaves the bus to time out.
- Writes to MASK, MODE and CLR honour byte lanes: intc_wr[k] covers bits [8k+7:8k].
- Input stage: irq_q is the sampled irq_i; irq_p <= irq_q.
- Pending update, per bit i, every cycle:
  - Level: pend[i] <= irq_q[i]; it follows the source, and CLR has no effect.
  - Edge: pend[i] <= (pend[i] & ~clr[i]) | (irq_q[i] & ~irq_p[i]).
  - Simultaneous clear and new edge: set wins, so no edge is lost.
- MODE write: pend bits whose MODE value changes are cleared in that cycle. irq_p is unaffected.
- Active set: act = pend & MASK.
- Outputs: irq_o <= |act; irq_id <= lowest set index of act, or 0 if act is empty.
- Reads are registered: intc_data_o is loaded in the access cycle and holds its value otherwise.

## Timing
- Reset values: intc_data_o = 0, intc_ready = 0, irq_o = 0, irq_id = 0. MASK, MODE, pend, irq_q and irq_p also reset to 0.
- Register access: request in cycle n, so intc_ready and intc_data_o are valid in cycle n+1, and intc_ready drops in n+2 regardless of intc_enable.
- A written MASK value affects irq_o 1 cycle after the ack cycle.
- irq_i to irq_o latency: 3 clock edges (sample, pend, irq_o) without synchronizer, 5 with it.
- A clear via CLR in the access cycle deasserts irq_o 2 edges later, unless another source is active.
- Reset asserted mid-access: intc_ready = 0 in the next cycle and the write is discarded.

## Configuration
- INTC_SYNC_EN defined: irq_i passes through a 2-flop synchronizer before irq_q. This is required for asynchronous sources and adds 2 cycles of latency.
- INTC_SYNC_EN undefined: irq_q <= irq_i directly. Sources must then be synchronous to clk, as GPIO interrupts are.
- Register map and behaviour are otherwise identical in both builds.

## Test plan
- Reset values: assert rst for 2 cycles, then read all five words. All outputs read 0; PEND, MASK, MODE, CLR and ID all read 0x0.
- Level source: with MASK=0x01 and MODE=0x00, hold irq_i[0]=1. irq_o=1 and irq_id=0 after 3 edges (5 with INTC_SYNC_EN). Drop irq_i[0] and irq_o returns to 0 three edges later.
- Edge latch and clear: with MODE=0x04 and MASK=0x04, apply a 1-cycle pulse on irq_i[2]. PEND reads 0x04 and irq_id=2. Write CLR=0x04 and PEND reads 0x0 with irq_o=0. Pulse again in the CLR access cycle and PEND stays 0x04.
- Priority: set MASK=0xFF and raise irq_i[5] and irq_i[3] together; irq_id=3. Mask bit 3 (MASK=0xF7) and irq_id=5.
- Byte lanes: write 0xAABBCCDD to MASK with intc_wr=4'b0010 and N_SRC=32. MASK reads 0x0000CC00.
- Unimplemented index: access address 0x14. intc_ready stays 0 for 10 cycles and no register changes.

Source files
------------

// File: rtl/intc.sv
// intc: 32-line max interrupt controller with level/edge pending and priority ID.
// Define INTC_SYNC_EN to add a 2-flop input synchronizer for async sources.
module intc #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic [31:0]      intc_address,
  input  logic [31:0]      intc_data_i,
  input  logic [3:0]       intc_wr,
  input  logic             intc_enable,
  output logic [31:0]      intc_data_o,
  output logic             intc_ready,
  output logic             irq_o,
  output logic [4:0]       irq_id
);

  localparam int W = N_SRC;

  logic [2:0]   idx;
  logic         hit;
  logic         acc;
  logic         wr;
  logic         rd;
  logic [31:0]  bm32;
  logic [W-1:0] bm;
  logic [W-1:0] dw;

  logic [W-1:0] irq_src;
  logic [W-1:0] irq_q;
  logic [W-1:0] irq_p;
  logic [W-1:0] pend;
  logic [W-1:0] mask;
  logic [W-1:0] mode;

  logic [W-1:0] mask_nx;
  logic [W-1:0] mode_nx;
  logic [W-1:0] mode_chg;
  logic [W-1:0] clr;
  logic [W-1:0] pend_nx;
  logic [W-1:0] act;
  logic [4:0]   id_nx;
  logic [31:0]  rdata;

  logic unused;
  assign unused = ^{intc_address[31:5], intc_address[1:0],
                    intc_data_i, bm32};

  function automatic logic [31:0] ext(input logic [W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[W-1:0] = v;
    return r;
  endfunction

`ifdef INTC_SYNC_EN
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
    end
  end
  assign irq_src = sync2;
`else
  assign irq_src = irq_i;
`endif

  assign idx = intc_address[4:2];
  assign hit = idx < 3'd5;
  // A held request acts only on the cycle before its ack.
  assign acc = intc_enable & ~intc_ready & hit;
  assign wr  = acc & (|intc_wr);
  assign rd  = acc & ~(|intc_wr);

  always_comb begin
    bm32 = '0;
    for (int k = 0; k < 4; k++)
      bm32[8*k +: 8] = {8{intc_wr[k]}};
  end

  assign bm = bm32[W-1:0];
  assign dw = intc_data_i[W-1:0];

  assign mask_nx = (wr && idx == 3'd1) ?
                   ((mask & ~bm) | (dw & bm)) : mask;
  assign mode_nx = (wr && idx == 3'd2) ?
                   ((mode & ~bm) | (dw & bm)) : mode;
  assign clr     = (wr && idx == 3'd3) ? (dw & bm) : '0;
  assign mode_chg = mode ^ mode_nx;

  // Edge set term is OR'd after the clear so a coincident edge survives.
  assign pend_nx = ~mode_chg &
                   ((mode & ((pend & ~clr) | (irq_q & ~irq_p))) |
                    (~mode & irq_q));

  assign act = pend & mask;

  always_comb begin
    id_nx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (act[i]) id_nx = 5'(i);
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd0:    rdata = ext(pend);
      3'd1:    rdata = ext(mask);
      3'd2:    rdata = ext(mode);
      3'd4:    rdata = {irq_o, 26'b0, irq_id};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q       <= '0;
      irq_p       <= '0;
      pend        <= '0;
      mask        <= '0;
      mode        <= '0;
      irq_o       <= 1'b0;
      irq_id      <= '0;
      intc_ready  <= 1'b0;
      intc_data_o <= '0;
    end else begin
      irq_q      <= irq_src;
      irq_p      <= irq_q;
      pend       <= pend_nx;
      mask       <= mask_nx;
      mode       <= mode_nx;
      irq_o      <= |act;
      irq_id     <= id_nx;
      intc_ready <= acc;
      if (rd) intc_data_o <= rdata;
    end
  end

endmodule

// File: tb/tb_intc.sv
// tb_intc: directed self-checking bench for intc (N_SRC=32).
// Latencies adapt to INTC_SYNC_EN.
module tb_intc;

`ifdef INTC_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  localparam int PRE = LAT - 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] irq_i = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  wr = '0;
  logic        en = 1'b0;
  logic [31:0] data_o;
  logic        ready;
  logic        irq_o;
  logic [4:0]  irq_id;
  logic [31:0] r;

  int compared = 0;
  int mismatched = 0;

  intc #(.N_SRC(32)) dut (
    .clk(clk),
    .rst(rst),
    .irq_i(irq_i),
    .intc_address(addr),
    .intc_data_i(wdat),
    .intc_wr(wr),
    .intc_enable(en),
    .intc_data_o(data_o),
    .intc_ready(ready),
    .irq_o(irq_o),
    .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] w, output logic [31:0] rd);
    @(negedge clk);
    addr = a; wdat = d; wr = w; en = 1'b1;
    @(posedge clk); #1;
    chk("bus_ack", {31'b0, ready}, 32'd1);
    rd = data_o;
    en = 1'b0;
    @(posedge clk); #1;
    chk("bus_drop", {31'b0, ready}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_id", {27'b0, irq_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(32'(i * 4), 32'd0, 4'b0000, r);
      chk("rst_word", r, 32'd0);
    end

    bus(32'h4, 32'h1, 4'hF, r);
    @(negedge clk);
    irq_i[0] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lvl_early", {31'b0, irq_o}, 32'd0);
    @(posedge clk);
    #1 chk("lvl_irq", {31'b0, irq_o}, 32'd1);
    chk("lvl_id", {27'b0, irq_id}, 32'd0);
    @(negedge clk);
    irq_i[0] = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lvl_hold", {31'b0, irq_o}, 32'd1);
    @(posedge clk);
    #1 chk("lvl_drop", {31'b0, irq_o}, 32'd0);

    bus(32'h8, 32'h4, 4'hF, r);
    bus(32'h4, 32'h4, 4'hF, r);
    @(negedge clk) irq_i[2] = 1'b1;
    @(negedge clk) irq_i[2] = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1 chk("edge_irq", {31'b0, irq_o}, 32'd1);
    chk("edge_id", {27'b0, irq_id}, 32'd2);
    bus(32'h0, 32'h0, 4'b0000, r);
    chk("edge_pend", r, 32'h4);
    bus(32'hC, 32'h4, 4'hF, r);
    chk("clr_irq", {31'b0, irq_o}, 32'd0);
    bus(32'h0, 32'h0, 4'b0000, r);
    chk("clr_pend", r, 32'h0);
    bus(32'hC, 32'h0, 4'b0000, r);
    chk("clr_read", r, 32'h0);

    @(negedge clk) irq_i[2] = 1'b1;
    @(negedge clk) irq_i[2] = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    bus(32'h0, 32'h0, 4'b0000, r);
    chk("repend", r, 32'h4);
    @(negedge clk) irq_i[2] = 1'b1;
    @(negedge clk) irq_i[2] = 1'b0;
    repeat (PRE - 1) @(negedge clk);
    addr = 32'hC; wdat = 32'h4; wr = 4'hF; en = 1'b1;
    @(posedge clk);
    #1 chk("race_ack", {31'b0, ready}, 32'd1);
    en = 1'b0;
    @(posedge clk);
    #1;
    bus(32'h0, 32'h0, 4'b0000, r);
    chk("race_pend", r, 32'h4);

    bus(32'h8, 32'h0, 4'hF, r);
    bus(32'h4, 32'hFF, 4'hF, r);
    @(negedge clk) irq_i = 32'h28;
    repeat (LAT + 1) @(posedge clk);
    #1 chk("prio_irq", {31'b0, irq_o}, 32'd1);
    chk("prio_id3", {27'b0, irq_id}, 32'd3);
    bus(32'h10, 32'h0, 4'b0000, r);
    chk("prio_idrd", r, 32'h8000_0003);
    bus(32'h4, 32'hF7, 4'hF, r);
    chk("prio_id5", {27'b0, irq_id}, 32'd5);
    bus(32'h10, 32'h0, 4'b0000, r);
    chk("prio_idrd5", r, 32'h8000_0005);
    bus(32'h0, 32'hFFFF_FFFF, 4'hF, r);
    bus(32'h0, 32'h0, 4'b0000, r);
    chk("pend_ro", r, 32'h28);

    bus(32'h4, 32'h0, 4'hF, r);
    bus(32'h4, 32'hAABB_CCDD, 4'b0010, r);
    bus(32'h4, 32'h0, 4'b0000, r);
    chk("lane_mask", r, 32'h0000_CC00);
    bus(32'h8, 32'hAABB_CCDD, 4'b1000, r);
    bus(32'h8, 32'h0, 4'b0000, r);
    chk("lane_mode", r, 32'hAA00_0000);
    bus(32'h8, 32'h0, 4'hF, r);

    @(negedge clk);
    addr = 32'h14; wdat = 32'hFFFF_FFFF; wr = 4'hF; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("unimpl_rdy", {31'b0, ready}, 32'd0);
    end
    @(negedge clk) en = 1'b0;
    bus(32'h4, 32'h0, 4'b0000, r);
    chk("unimpl_mask", r, 32'h0000_CC00);
    bus(32'h8, 32'h0, 4'b0000, r);
    chk("unimpl_mode", r, 32'h0);

    @(negedge clk);
    addr = 32'h4; wdat = 32'hFFFF; wr = 4'hF; en = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 chk("rstacc_rdy", {31'b0, ready}, 32'd0);
    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    bus(32'h4, 32'h0, 4'b0000, r);
    chk("rstacc_mask", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
